csr_file_m: RTL and testbench

//   Parametrised machine-mode CSR file with trap sequencing, the successor of the 4-entry CSR store.

---
 rtl/csr_file_m.sv | 104 ++++++++++
 tb/tb_csr_file_m.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with interrupt trap entry, MRET exit and 64-bit counters
module csr_file_m #(
  parameter int XLEN = 32,
  parameter int NUM_IRQ = 3,
  parameter int HAS_COUNTERS = 1,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  input  logic [1:0]         csr_op,
  input  logic               csr_rd,
  input  logic [XLEN-1:0]    pc,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               is_mret,
  input  logic               inst_retire,
  output logic [XLEN-1:0]    rdata,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               illegal_csr
);
  logic            st_mie, st_mpie;
  logic [2:0]      mie_r, irq3, pending;
  logic [XLEN-1:0] mtvec, mepc, mcause, cur, nv;
  logic [63:0]     mcycle, minstret;
  logic [3:0]      code;
  logic            mapped, legal, wr, we, take, wr_cyc, wr_ret;
  function automatic logic [XLEN-1:0] spread(input logic [2:0] v);
    return XLEN'({v[2], 3'b0, v[1], 3'b0, v[0], 3'b0});
  endfunction
  assign irq3 = 3'(irq);
  always_comb begin
    mapped = 1'b1;
    cur = '0;
    case (csr_addr)
      12'h300: cur = XLEN'({st_mpie, 3'b0, st_mie, 3'b0});
      12'h304: cur = spread(mie_r);
      12'h305: cur = {mtvec[XLEN-1:2], 1'b0, mtvec[0]};
      12'h341: cur = {mepc[XLEN-1:2], 2'b00};
      12'h342: cur = mcause;
      12'h344: cur = spread(irq3);
      12'hB00: begin cur = XLEN'(mcycle[31:0]);    mapped = HAS_COUNTERS != 0; end
      12'hB80: begin cur = XLEN'(mcycle[63:32]);   mapped = HAS_COUNTERS != 0; end
      12'hB02: begin cur = XLEN'(minstret[31:0]);  mapped = HAS_COUNTERS != 0; end
      12'hB82: begin cur = XLEN'(minstret[63:32]); mapped = HAS_COUNTERS != 0; end
      default: mapped = 1'b0;
    endcase
  end
  assign wr          = csr_op != 2'b00;
  assign legal       = mapped & ~(wr & csr_addr == 12'h344);
  assign illegal_csr = (wr | csr_rd) & ~legal;
  assign rdata       = csr_rd & legal ? cur : '0;
  assign nv          = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? cur | csr_wdata : cur & ~csr_wdata;
  assign pending     = irq3 & mie_r;
  assign take        = st_mie & |pending & ~is_mret;
  assign code        = pending[2] ? 4'd11 : pending[1] ? 4'd7 : 4'd3;
  assign redirect    = take | is_mret;
  assign redirect_pc = is_mret ? {mepc[XLEN-1:2], 2'b00}
                     : {mtvec[XLEN-1:2], 2'b00} + (mtvec[0] ? XLEN'({code, 2'b00}) : '0);
  // a redirecting instruction does not commit, so its CSR write is dropped
  assign we     = wr & legal & ~redirect;
  assign wr_cyc = we & (csr_addr == 12'hB00 | csr_addr == 12'hB80);
  assign wr_ret = we & (csr_addr == 12'hB02 | csr_addr == 12'hB82);
  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mie_r    <= '0;
      mtvec    <= MTVEC_RESET;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (take) begin
        mepc    <= pc;
        mcause  <= {1'b1, (XLEN-1)'(code)};
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (is_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (we) begin
        case (csr_addr)
          12'h300: begin st_mie <= nv[3]; st_mpie <= nv[7]; end
          12'h304: mie_r  <= {nv[11], nv[7], nv[3]};
          12'h305: mtvec  <= nv;
          12'h341: mepc   <= nv;
          12'h342: mcause <= nv;
          default: ;
        endcase
      end
      if (HAS_COUNTERS != 0) begin
        mcycle <= wr_cyc ? {csr_addr == 12'hB80 ? nv[31:0] : mcycle[63:32],
                            csr_addr == 12'hB00 ? nv[31:0] : mcycle[31:0]}
                         : mcycle + 64'd1;
        minstret <= wr_ret ? {csr_addr == 12'hB82 ? nv[31:0] : minstret[63:32],
                              csr_addr == 12'hB02 ? nv[31:0] : minstret[31:0]}
                           : minstret + 64'(inst_retire & ~redirect);
      end
    end
  end
endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: directed self-checking bench for csr_file_m
module tb_csr_file_m;
  localparam logic [31:0] MTR = 32'h0000_0100;
  logic        clk = 1'b0, rst = 1'b1;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0, pc = '0;
  logic [1:0]  csr_op = '0;
  logic        csr_rd = 1'b0, is_mret = 1'b0, inst_retire = 1'b0;
  logic [2:0]  irq = '0;
  logic [31:0] rdata, redirect_pc;
  logic        redirect, illegal_csr;
  int checks = 0, errors = 0;
  csr_file_m #(.XLEN(32), .NUM_IRQ(3), .HAS_COUNTERS(1), .MTVEC_RESET(MTR)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_op(csr_op),
    .csr_rd(csr_rd), .pc(pc), .irq(irq), .is_mret(is_mret), .inst_retire(inst_retire),
    .rdata(rdata), .redirect(redirect), .redirect_pc(redirect_pc), .illegal_csr(illegal_csr));
  always #5 clk = ~clk;
  task automatic tick; @(posedge clk); #1; endtask
  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_addr = a; csr_op = op; csr_wdata = d; csr_rd = 1'b0;
    tick;
    csr_op = 2'b00;
  endtask
  task automatic rd(input logic [11:0] a);
    csr_addr = a; csr_op = 2'b00; csr_rd = 1'b1;
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; tick; tick; rst = 1'b0;
    rd(12'h305);
    checks++; if (rdata !== MTR) begin errors++; $display("FAIL rst_mtvec got %h exp %h", rdata, MTR); end
    rd(12'h300);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mstatus got %h exp 0", rdata); end
    rd(12'h341);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h exp 0", rdata); end
    rd(12'h342);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mcause got %h exp 0", rdata); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got %b exp 0", redirect); end
  endtask
  task automatic test_vectored_trap;
    wr(12'h300, 2'b01, 32'h8);
    wr(12'h304, 2'b01, 32'h80);
    wr(12'h305, 2'b01, 32'h1001);
    pc = 32'h200; irq = 3'b010; #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL vec_redirect got %b exp 1", redirect); end
    checks++; if (redirect_pc !== 32'h101C) begin errors++; $display("FAIL vec_pc got %h exp 101c", redirect_pc); end
    tick; irq = 3'b000;
    rd(12'h341);
    checks++; if (rdata !== 32'h200) begin errors++; $display("FAIL vec_mepc got %h exp 200", rdata); end
    rd(12'h342);
    checks++; if (rdata !== 32'h8000_0007) begin errors++; $display("FAIL vec_mcause got %h exp 80000007", rdata); end
    rd(12'h300);
    checks++; if (rdata !== 32'h80) begin errors++; $display("FAIL vec_mstatus got %h exp 80", rdata); end
  endtask
  task automatic test_priority_mret;
    wr(12'h305, 2'b01, 32'h400);
    wr(12'h304, 2'b01, 32'h888);
    wr(12'h300, 2'b01, 32'h8);
    pc = 32'h300; irq = 3'b111; #1;
    checks++; if (redirect_pc !== 32'h400) begin errors++; $display("FAIL prio_pc got %h exp 400", redirect_pc); end
    tick; irq = 3'b000;
    rd(12'h342);
    checks++; if (rdata !== 32'h8000_000B) begin errors++; $display("FAIL prio_mcause got %h exp 8000000b", rdata); end
    is_mret = 1'b1; #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h300) begin errors++; $display("FAIL mret_pc got %b/%h exp 1/300", redirect, redirect_pc); end
    tick; is_mret = 1'b0;
    rd(12'h300);
    checks++; if (rdata !== 32'h88) begin errors++; $display("FAIL mret_mstatus got %h exp 88", rdata); end
    pc = 32'h500; irq = 3'b111; is_mret = 1'b1; #1;
    checks++; if (redirect_pc !== 32'h300) begin errors++; $display("FAIL mret_wins_pc got %h exp 300", redirect_pc); end
    tick; is_mret = 1'b0; #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h400) begin errors++; $display("FAIL late_irq got %b/%h exp 1/400", redirect, redirect_pc); end
    tick; irq = 3'b000;
    rd(12'h341);
    checks++; if (rdata !== 32'h500) begin errors++; $display("FAIL late_irq_mepc got %h exp 500", rdata); end
  endtask
  task automatic test_set_clear_illegal;
    wr(12'h304, 2'b01, 32'h0);
    wr(12'h304, 2'b10, 32'h8);
    rd(12'h304);
    checks++; if (rdata !== 32'h8) begin errors++; $display("FAIL mie_rs got %h exp 8", rdata); end
    wr(12'h304, 2'b11, 32'h8);
    rd(12'h304);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mie_rc got %h exp 0", rdata); end
    csr_rd = 1'b0; csr_addr = 12'h344; csr_op = 2'b01; csr_wdata = 32'h888; #1;
    checks++; if (illegal_csr !== 1'b1) begin errors++; $display("FAIL mip_rw_illegal got %b exp 1", illegal_csr); end
    csr_op = 2'b10; csr_wdata = 32'h0; #1;
    checks++; if (illegal_csr !== 1'b1) begin errors++; $display("FAIL mip_rs0_illegal got %b exp 1", illegal_csr); end
    csr_addr = 12'h7C0; csr_op = 2'b01; csr_wdata = 32'hFFFF_FFFF; #1;
    checks++; if (illegal_csr !== 1'b1) begin errors++; $display("FAIL unmapped_illegal got %b exp 1", illegal_csr); end
    tick; csr_op = 2'b00;
    rd(12'h7C0);
    checks++; if (illegal_csr !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %b/%h exp 1/0", illegal_csr, rdata); end
    irq = 3'b101;
    rd(12'h344);
    checks++; if (rdata !== 32'h808 || illegal_csr !== 1'b0) begin errors++; $display("FAIL mip_rd got %h/%b exp 808/0", rdata, illegal_csr); end
    irq = 3'b000;
    rd(12'h304);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mie_after_illegal got %h exp 0", rdata); end
    csr_rd = 1'b0; csr_addr = 12'h305; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_disabled got %h exp 0", rdata); end
  endtask
  task automatic test_fields;
    wr(12'h300, 2'b01, 32'hFFFF_FFFF);
    rd(12'h300);
    checks++; if (rdata !== 32'h88) begin errors++; $display("FAIL mstatus_mask got %h exp 88", rdata); end
    wr(12'h305, 2'b01, 32'hFFFF_FFFF);
    rd(12'h305);
    checks++; if (rdata !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mtvec_mask got %h exp fffffffd", rdata); end
    wr(12'h341, 2'b01, 32'h55);
    rd(12'h341);
    checks++; if (rdata !== 32'h54) begin errors++; $display("FAIL mepc_mask got %h exp 54", rdata); end
    wr(12'h300, 2'b01, 32'h0);
  endtask
  task automatic test_counters;
    wr(12'hB80, 2'b01, 32'h0);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB00);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_wr got %h exp ffffffff", rdata); end
    tick;
    rd(12'hB00);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mcycle_carry_lo got %h exp 0", rdata); end
    rd(12'hB80);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL mcycle_carry_hi got %h exp 1", rdata); end
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
    tick;
    rd(12'hB00);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_lo got %h exp 0", rdata); end
    rd(12'hB80);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_hi got %h exp 0", rdata); end
    wr(12'hB02, 2'b01, 32'h5);
    wr(12'hB82, 2'b01, 32'h0);
    inst_retire = 1'b1; tick; inst_retire = 1'b0;
    rd(12'hB02);
    checks++; if (rdata !== 32'h6) begin errors++; $display("FAIL minstret_inc got %h exp 6", rdata); end
    wr(12'h305, 2'b01, 32'h800);
    wr(12'h304, 2'b01, 32'h8);
    wr(12'h300, 2'b01, 32'h8);
    pc = 32'h40; irq = 3'b001; inst_retire = 1'b1; #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h800) begin errors++; $display("FAIL sw_trap got %b/%h exp 1/800", redirect, redirect_pc); end
    tick; irq = 3'b000; inst_retire = 1'b0;
    rd(12'hB02);
    checks++; if (rdata !== 32'h6) begin errors++; $display("FAIL minstret_trap got %h exp 6", rdata); end
    rd(12'h342);
    checks++; if (rdata !== 32'h8000_0003) begin errors++; $display("FAIL sw_mcause got %h exp 80000003", rdata); end
  endtask
  task automatic test_trap_drops_write;
    wr(12'h300, 2'b01, 32'h8);
    pc = 32'h1234; irq = 3'b001;
    csr_addr = 12'h341; csr_op = 2'b01; csr_wdata = 32'h55; csr_rd = 1'b0;
    tick; csr_op = 2'b00; irq = 3'b000;
    rd(12'h341);
    checks++; if (rdata !== 32'h1234) begin errors++; $display("FAIL drop_mepc got %h exp 1234", rdata); end
    rd(12'h300);
    checks++; if (rdata !== 32'h80) begin errors++; $display("FAIL drop_mstatus got %h exp 80", rdata); end
  endtask
  task automatic test_reset_during_trap;
    wr(12'h300, 2'b01, 32'h8);
    pc = 32'h888; irq = 3'b001; rst = 1'b1;
    tick; rst = 1'b0; irq = 3'b000;
    rd(12'hB00);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mcycle got %h exp 0", rdata); end
    rd(12'h341);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_trap_mepc got %h exp 0", rdata); end
    rd(12'h342);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_trap_mcause got %h exp 0", rdata); end
    rd(12'h305);
    checks++; if (rdata !== MTR) begin errors++; $display("FAIL rst_trap_mtvec got %h exp %h", rdata, MTR); end
    rd(12'hB02);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_minstret got %h exp 0", rdata); end
  endtask
  initial begin
    test_reset;
    test_vectored_trap;
    test_priority_mret;
    test_set_clear_illegal;
    test_fields;
    test_counters;
    test_trap_drops_write;
    test_reset_during_trap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
